// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock sequencer.
//   KEY_STAR / KEY_HASH : key codes for '*' and '#' as delivered by the keypad scanner
//   state_t             : sequencer states
//   is_digit()          : true for key codes 0-9
package lock_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        OPEN,
        PROG,
        LOCKOUT
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter used for both the unlock window and the lockout period.
//   clock : system clock
//   reset : synchronous active-high reset, clears the count
//   load  : load 'value' into the counter (takes priority over counting)
//   value : cycle count to load
//   done  : high for the single cycle in which the count sits at 1; the
//           owner acts on it at the following edge, giving exactly 'value'
//           cycles between the load edge and the expiry edge
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            // Stops at zero; never wraps.
            count <= count - 1'b1;
        end
    end

    assign done = (count == W'(1)) && !load;

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: collects digit entries, compares them with the stored
// code, opens the lock, locks out after repeated failures and lets the code be
// reprogrammed while open.
//   clock     : system clock (rising edge)
//   reset     : synchronous active-high reset
//   Code      : key code from the keypad scanner (0-9, A='*', B='#', C-F ignored)
//   Valid     : high while a debounced key is held
//   unlock    : lock open
//   alarm     : lockout in progress
//   err       : one-cycle pulse per rejected entry
//   prog_mode : new code being entered
//   digit_cnt : digits in the current entry, saturating at DIGITS
module lock_controller
    import lock_pkg::*;
#(
    parameter int          DIGITS         = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 50_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Code,
    input  logic       Valid,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic       prog_mode,
    output logic [2:0] digit_cnt
);

    localparam int BW   = 4 * DIGITS;
    localparam int MAXC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [3:0] DIG_N = 4'(DIGITS);
    localparam logic [3:0] TRIES = 4'(MAX_TRIES);

    state_t          state, state_n;
    logic            valid_q;
    logic [BW-1:0]   entry, entry_n;
    logic [BW-1:0]   stored, stored_n;
    logic [3:0]      cnt, cnt_n;
    logic            ovf, ovf_n;
    logic [3:0]      fails, fails_n;
    logic            err_n;
    logic            tmr_load;
    logic [TW-1:0]   tmr_value;
    logic            tmr_done;

    logic key_ev, digit_ev, star_ev, hash_ev;
    logic full_entry;

    // Internal count can reach 8 (DIGITS=8) but the port is 3 bits wide.
    function automatic logic [2:0] sat_cnt(input logic [3:0] c);
        return (c > 4'd7) ? 3'd7 : c[2:0];
    endfunction

    lock_timer #(
        .W (TW)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    // Rising edge of Valid is the only key event; holding a key yields nothing more.
    assign key_ev     = Valid && !valid_q;
    assign digit_ev   = key_ev && is_digit(Code);
    assign star_ev    = key_ev && (Code == KEY_STAR);
    assign hash_ev    = key_ev && (Code == KEY_HASH);
    assign full_entry = (cnt == DIG_N) && !ovf;

    always_comb begin
        state_n   = state;
        entry_n   = entry;
        cnt_n     = cnt;
        ovf_n     = ovf;
        fails_n   = fails;
        stored_n  = stored;
        err_n     = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = TW'(UNLOCK_CYCLES);

        case (state)
            ENTRY, PROG: begin
                if (digit_ev) begin
                    if (cnt < DIG_N) begin
                        entry_n = BW'({entry, Code});
                        cnt_n   = cnt + 4'd1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else if (star_ev) begin
                    // Clears the entry in ENTRY; aborts programming in PROG.
                    entry_n = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = ENTRY;
                end else if (hash_ev) begin
                    if (state == ENTRY) begin
                        state_n = CHECK;
                    end else begin
                        if (full_entry) begin
                            stored_n = entry;
                        end else begin
                            err_n = 1'b1;
                        end
                        entry_n = '0;
                        cnt_n   = '0;
                        ovf_n   = 1'b0;
                        state_n = ENTRY;
                    end
                end
            end

            CHECK: begin
                // Key events arriving now are dropped.
                entry_n = '0;
                cnt_n   = '0;
                ovf_n   = 1'b0;
                if (full_entry && (entry == stored)) begin
                    fails_n   = '0;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(UNLOCK_CYCLES);
                    state_n   = OPEN;
                end else begin
                    err_n   = 1'b1;
                    fails_n = fails + 4'd1;
                    if (fails_n >= TRIES) begin
                        tmr_load  = 1'b1;
                        tmr_value = TW'(LOCKOUT_CYCLES);
                        state_n   = LOCKOUT;
                    end else begin
                        state_n = ENTRY;
                    end
                end
            end

            OPEN: begin
                // Expiry and '#' on the same edge both mean a single return to ENTRY.
                if (tmr_done || hash_ev) begin
                    state_n = ENTRY;
                end else if (star_ev) begin
                    state_n = PROG;
                end
            end

            LOCKOUT: begin
                if (tmr_done) begin
                    fails_n = '0;
                    state_n = ENTRY;
                end
            end

            default: begin
                state_n = ENTRY;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ENTRY;
            valid_q   <= 1'b0;
            entry     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            fails     <= '0;
            stored    <= DEFAULT_CODE[BW-1:0];
            unlock    <= 1'b0;
            alarm     <= 1'b0;
            err       <= 1'b0;
            prog_mode <= 1'b0;
            digit_cnt <= '0;
        end else begin
            state     <= state_n;
            valid_q   <= Valid;
            entry     <= entry_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            fails     <= fails_n;
            stored    <= stored_n;
            unlock    <= (state_n == OPEN);
            alarm     <= (state_n == LOCKOUT);
            err       <= err_n;
            prog_mode <= (state_n == PROG);
            digit_cnt <= sat_cnt(cnt_n);
        end
    end

endmodule
